// File: rtl/decryption_128.sv
// AES-128 inverse cipher, one round per clock: valid 21 edges after start (11 on a key-cache hit).
// start is taken only while ready; DECRYPTION_128_KEY_CACHE_EN keeps the last key's rk10 to skip expansion.
module decryption_128 #(
   parameter int N = 128,
   parameter int R = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N-1:0]        cipher_text,
   input  logic [N-1:0]        key,
   output logic                ready,
   output logic                busy,
   output logic [N-1:0]        plain_text,
   output logic                valid,
   output logic [$clog2(R):0]  round
);
   localparam int RW = $clog2(R) + 1;

   typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL} fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // GF(2^8) inverse as x^254, which also maps 0 to 0.
   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] isbox(input logic [7:0] x);
      return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [RW-1:0] r);
      logic [7:0] c;
      c = 8'h01;
      for (int i = 1; i < R; i++) begin
         if (i < int'(r)) c = xtime(c);
      end
      return c;
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Undo one expansion step: recover the previous round key from the current one.
   function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      int src;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            src = ((c - r + 4) % 4) * 4 + r;
            o[127-8*(c*4+r) -: 8] = isbox(s[127-8*src -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   fsm_e          fsm_q, fsm_d;
   logic [N-1:0]  st_q, st_d;
   logic [N-1:0]  rk_q, rk_d;
   logic [RW-1:0] round_q, round_d;
   logic [N-1:0]  pt_q, pt_d;
   logic          valid_q, valid_d;
`ifdef DECRYPTION_128_KEY_CACHE_EN
   logic [N-1:0]  ckey_q, ckey_d;
   logic [N-1:0]  crk_q, crk_d;
   logic          cvld_q, cvld_d;
   logic          hit;
`endif

   always_comb begin
      fsm_d   = fsm_q;
      st_d    = st_q;
      rk_d    = rk_q;
      round_d = round_q;
      pt_d    = pt_q;
      valid_d = 1'b0;
`ifdef DECRYPTION_128_KEY_CACHE_EN
      ckey_d  = ckey_q;
      crk_d   = crk_q;
      cvld_d  = cvld_q;
      hit     = cvld_q && (key == ckey_q);
`endif
      unique case (fsm_q)
         S_IDLE: begin
            if (start) begin
               // Ciphertext parks in the state register until INIT whitens it.
               st_d = cipher_text;
`ifdef DECRYPTION_128_KEY_CACHE_EN
               if (hit) begin
                  fsm_d   = S_INIT;
                  rk_d    = crk_q;
                  round_d = RW'(R);
               end else begin
                  fsm_d   = S_KEXP;
                  rk_d    = key;
                  round_d = RW'(1);
                  ckey_d  = key;
                  cvld_d  = 1'b0;
               end
`else
               fsm_d   = S_KEXP;
               rk_d    = key;
               round_d = RW'(1);
`endif
            end
         end
         S_KEXP: begin
            rk_d = key_fwd(rk_q, rcon(round_q));
            if (round_q == RW'(R)) begin
               fsm_d = S_INIT;
`ifdef DECRYPTION_128_KEY_CACHE_EN
               crk_d  = rk_d;
               cvld_d = 1'b1;
`endif
            end else begin
               round_d = round_q + RW'(1);
            end
         end
         S_INIT: begin
            st_d    = st_q ^ rk_q;
            rk_d    = key_inv(rk_q, rcon(round_q));
            round_d = round_q - RW'(1);
            fsm_d   = S_ROUND;
         end
         S_ROUND: begin
            st_d    = inv_mix(inv_shift_sub(st_q) ^ rk_q);
            rk_d    = key_inv(rk_q, rcon(round_q));
            round_d = round_q - RW'(1);
            if (round_q == RW'(1)) fsm_d = S_FINAL;
         end
         S_FINAL: begin
            pt_d    = inv_shift_sub(st_q) ^ rk_q;
            valid_d = 1'b1;
            round_d = '0;
            fsm_d   = S_IDLE;
         end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= S_IDLE;
         st_q    <= '0;
         rk_q    <= '0;
         round_q <= '0;
         pt_q    <= '0;
         valid_q <= 1'b0;
`ifdef DECRYPTION_128_KEY_CACHE_EN
         ckey_q  <= '0;
         crk_q   <= '0;
         cvld_q  <= 1'b0;
`endif
      end else begin
         fsm_q   <= fsm_d;
         st_q    <= st_d;
         rk_q    <= rk_d;
         round_q <= round_d;
         pt_q    <= pt_d;
         valid_q <= valid_d;
`ifdef DECRYPTION_128_KEY_CACHE_EN
         ckey_q  <= ckey_d;
         crk_q   <= crk_d;
         cvld_q  <= cvld_d;
`endif
      end
   end

   assign ready      = (fsm_q == S_IDLE);
   assign busy       = !ready;
   assign plain_text = pt_q;
   assign valid      = valid_q;
   assign round      = round_q;
endmodule

// File: tb/tb_decryption_128.sv
// Bench for decryption_128: table-driven AES model plus a per-cycle compare of handshake, latency and data.
module tb_decryption_128;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h0f1571c947d9e8590cb7add6af7f6798;
   localparam logic [127:0] C2 = 128'hff0b844a0853bf7c6934ab4364148fb9;
   localparam logic [127:0] P2 = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] cipher_text;
   logic [127:0] key;
   logic         ready;
   logic         busy;
   logic [127:0] plain_text;
   logic         valid;
   logic [4:0]   round;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];

   decryption_128 dut (
      .clk(clk), .rst(rst), .start(start), .cipher_text(cipher_text), .key(key),
      .ready(ready), .busy(busy), .plain_text(plain_text), .valid(valid), .round(round)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [15:0] t;
      t = {v, v} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box built by walking generator 3 and its inverse through the field.
   task automatic build_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
      for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
   endtask

   function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] c);
      logic [7:0] w [44][4];
      logic [7:0] t [4];
      logic [7:0] s [16];
      logic [7:0] u [16];
      logic [7:0] rc, a0, a1, a2, a3;
      logic [127:0] o;
      rc = 8'h01;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) w[i][j] = k[127-8*(4*i+j) -: 8];
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
         if (i % 4 == 0) begin
            t[0] = sbox[w[i-1][1]] ^ rc;
            t[1] = sbox[w[i-1][2]];
            t[2] = sbox[w[i-1][3]];
            t[3] = sbox[w[i-1][0]];
            rc = xt(rc);
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
      end
      for (int b = 0; b < 16; b++) s[b] = c[127-8*b -: 8] ^ w[40 + b/4][b%4];
      for (int r = 9; r >= 0; r--) begin
         for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
               u[4*col+row] = isbox[s[4*((col - row + 4) % 4) + row]];
         for (int b = 0; b < 16; b++) s[b] = u[b] ^ w[4*r + b/4][b%4];
         if (r > 0) begin
            for (int col = 0; col < 4; col++) begin
               a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
               s[4*col]   = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
               s[4*col+1] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
               s[4*col+2] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
               s[4*col+3] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
            end
         end
      end
      o = '0;
      for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
      return o;
   endfunction

   // Expected round index k edges after the accepting edge (full-expansion path).
   function automatic int exp_round(input int k);
      if (k <= 9) return k + 1;
      if (k == 10) return 10;
      if (k <= 20) return 20 - k;
      return 0;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Compare process: owns the model state and every comparison.
   initial begin : compare
      bit           pending, hit_op, cache_vld, exp_valid, exp_ready;
      int           acc_cyc, lat, k;
      logic [127:0] exp_pt, last_pt, cache_key;
      pending = 0; hit_op = 0; cache_vld = 0;
      acc_cyc = 0; lat = 21;
      exp_pt = '0; last_pt = '0; cache_key = '0;
      build_tables();
      chk("sbox_00", {120'h0, sbox[0]}, 128'h63);
      chk("sbox_53", {120'h0, sbox[8'h53]}, 128'hed);
      chk("isbox_00", {120'h0, isbox[0]}, 128'h52);
      chk("model_c1", model_dec(K1, C1), P1);
      chk("model_c2", model_dec(K2, C2), P2);
      chk("model_b", model_dec(KB, CB), PB);
      forever begin
         @(negedge clk);
         if (rst) begin
            pending = 0;
            cache_vld = 0;
            last_pt = '0;
            chk("rst_ready", {127'h0, ready}, 128'h1);
            chk("rst_busy", {127'h0, busy}, 128'h0);
            chk("rst_valid", {127'h0, valid}, 128'h0);
            chk("rst_plain", plain_text, 128'h0);
            chk("rst_round", {123'h0, round}, 128'h0);
         end else begin
            k = cyc - acc_cyc;
            exp_valid = pending && (k == lat);
            exp_ready = !pending || exp_valid;
            chk("ready", {127'h0, ready}, {127'h0, exp_ready});
            chk("busy", {127'h0, busy}, {127'h0, !exp_ready});
            chk("valid", {127'h0, valid}, {127'h0, exp_valid});
            if (exp_valid) begin
               last_pt = exp_pt;
               pending = 0;
            end
            chk("plain_text", plain_text, last_pt);
            if (!pending) chk("round_idle", {123'h0, round}, 128'h0);
            else if (!hit_op) chk("round_seq", {123'h0, round}, 128'(exp_round(k)));
            if (start && exp_ready) begin
               pending = 1;
               acc_cyc = cyc + 1;
               exp_pt  = model_dec(key, cipher_text);
`ifdef DECRYPTION_128_KEY_CACHE_EN
               hit_op = cache_vld && (key == cache_key);
`else
               hit_op = 0;
`endif
               lat = hit_op ? 11 : 21;
               cache_key = key;
               cache_vld = 1;
            end
         end
      end
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // All driver activity happens 1 time unit after a rising edge.
   task automatic wait_ready();
      for (int i = 0; i < 60; i++) begin
         if (ready) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid) break;
      end
   endtask

   task automatic issue(input logic [127:0] k, input logic [127:0] c);
      wait_ready();
      start = 1'b1; key = k; cipher_text = c;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin : drive
      logic [127:0] prev_key;
      rst = 1'b1; start = 1'b0; key = '0; cipher_text = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      issue(K1, C1); wait_valid();
      issue(K2, C2); wait_valid();

      // Back-to-back: start again in the valid cycle.
      issue(KB, CB); wait_valid();
      start = 1'b1; key = K1; cipher_text = C1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_valid();

      // Inputs thrash while busy; only the accepted pair matters.
      wait_ready();
      start = 1'b1; key = K2; cipher_text = C2;
      @(posedge clk);
      for (int i = 0; i < 18; i++) begin
         #1 start = 1'b1; key = rnd128(); cipher_text = rnd128();
         @(posedge clk);
      end
      #1 start = 1'b0;
      wait_valid();

      // Reset in the middle of an operation.
      issue(KB, CB);
      for (int i = 0; i < 30; i++) begin
         if (round == 5'd5) break;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(KB, CB); wait_valid();

      // Randomised traffic with frequent key reuse.
      prev_key = KB;
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 2) != 0) prev_key = rnd128();
         issue(prev_key, rnd128());
         wait_valid();
      end

      // Same key twice, then a new key, then reset and the same key again.
      issue(K1, rnd128()); wait_valid();
      issue(K1, rnd128()); wait_valid();
      issue(K2, rnd128()); wait_valid();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(K2, rnd128()); wait_valid();

      repeat (4) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
